// File: rtl/srff_bank.sv
// srff_bank: N independent set/reset flags with per-channel conflict mode,
// optional rising-edge qualification of S/R and optional auto-clear timeout.
//
// Ports:
//   clk      rising-edge clock
//   ares_L   asynchronous active-low reset
//   mode     2 bits per channel: 00 reset-wins, 01 set-wins, 10 hold, 11 toggle
//   S, R     per-channel set / reset requests
//   Q        registered flags
//   conflict registered pulse: set and reset events coincided
//   rise     registered pulse: Q went 0->1
module srff_bank #(
  parameter int N       = 8,
  parameter int EDGE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           ares_L,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   S,
  input  logic [N-1:0]   R,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   conflict,
  output logic [N-1:0]   rise
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [N-1:0] es;
  logic [N-1:0] er;
  logic [N-1:0] q_nxt;

  // Effective events: raw levels, or rising edges against last-cycle samples.
  if (EDGE != 0) begin : g_edge
    logic [N-1:0] s_d;
    logic [N-1:0] r_d;

    always_ff @(posedge clk or negedge ares_L) begin
      if (!ares_L) begin
        s_d <= '0;
        r_d <= '0;
      end else begin
        s_d <= S;
        r_d <= R;
      end
    end

    assign es = S & ~s_d;
    assign er = R & ~r_d;
  end else begin : g_level
    assign es = S;
    assign er = R;
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0] m;
    logic       both;
    logic       sel_set;
    logic       sel_clr;
    logic       ev_set;
    logic       ev_clr;

    assign m    = mode[2*i +: 2];
    assign both = es[i] & er[i];

    // Resolution of a simultaneous set/reset; hold selects neither.
    always_comb begin
      sel_set = 1'b0;
      sel_clr = 1'b0;
      unique case (m)
        2'b00: sel_clr = 1'b1;
        2'b01: sel_set = 1'b1;
        2'b10: ;
        2'b11: begin
          sel_set = ~Q[i];
          sel_clr = Q[i];
        end
        default: ;
      endcase
    end

    assign ev_set = (es[i] & ~er[i]) | (both & sel_set);
    assign ev_clr = (er[i] & ~es[i]) | (both & sel_clr);

    if (TIMEOUT > 0) begin : g_to
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nxt;
      logic          qn;

      // An event always beats expiry; without one, a set flag counts down
      // and drops on the cycle the counter would reach zero.
      always_comb begin
        qn      = Q[i];
        cnt_nxt = cnt;
        if (ev_set) begin
          qn      = 1'b1;
          cnt_nxt = CW'(TIMEOUT);
        end else if (ev_clr) begin
          qn      = 1'b0;
          cnt_nxt = '0;
        end else if (Q[i]) begin
          if (cnt > CW'(1)) begin
            cnt_nxt = cnt - CW'(1);
          end else if (cnt == CW'(1)) begin
            qn      = 1'b0;
            cnt_nxt = '0;
          end
        end
      end

      always_ff @(posedge clk or negedge ares_L) begin
        if (!ares_L) begin
          cnt <= '0;
        end else begin
          cnt <= cnt_nxt;
        end
      end

      assign q_nxt[i] = qn;
    end else begin : g_nto
      assign q_nxt[i] = ev_set ? 1'b1 : (ev_clr ? 1'b0 : Q[i]);
    end
  end

  always_ff @(posedge clk or negedge ares_L) begin
    if (!ares_L) begin
      Q        <= '0;
      conflict <= '0;
      rise     <= '0;
    end else begin
      Q        <= q_nxt;
      conflict <= es & er;
      rise     <= ~Q & q_nxt;
    end
  end

endmodule

// File: tb/tb_srff_bank.sv
// tb_srff_bank: self-checking bench for srff_bank using four instances
// (level N=8, edge N=4, timeout 5, timeout 3) and a shared scoreboard.
module tb_srff_bank;

  logic clk;
  logic ares_L;

  logic [15:0] a_mode;
  logic [7:0]  a_s, a_r, a_q, a_c, a_ri;
  logic [7:0]  b_mode;
  logic [3:0]  b_s, b_r, b_q, b_c, b_ri;
  logic [3:0]  c_mode;
  logic [1:0]  c_s, c_r, c_q, c_c, c_ri;
  logic [3:0]  d_mode;
  logic [1:0]  d_s, d_r, d_q, d_c, d_ri;

  srff_bank #(.N(8), .EDGE(0), .TIMEOUT(0)) u_a (
    .clk(clk), .ares_L(ares_L), .mode(a_mode), .S(a_s), .R(a_r),
    .Q(a_q), .conflict(a_c), .rise(a_ri)
  );
  srff_bank #(.N(4), .EDGE(1), .TIMEOUT(0)) u_b (
    .clk(clk), .ares_L(ares_L), .mode(b_mode), .S(b_s), .R(b_r),
    .Q(b_q), .conflict(b_c), .rise(b_ri)
  );
  srff_bank #(.N(2), .EDGE(0), .TIMEOUT(5)) u_c (
    .clk(clk), .ares_L(ares_L), .mode(c_mode), .S(c_s), .R(c_r),
    .Q(c_q), .conflict(c_c), .rise(c_ri)
  );
  srff_bank #(.N(2), .EDGE(0), .TIMEOUT(3)) u_d (
    .clk(clk), .ares_L(ares_L), .mode(d_mode), .S(d_s), .R(d_r),
    .Q(d_q), .conflict(d_c), .rise(d_ri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         unit;
    string      name;
    logic [7:0] q;
    logic [7:0] c;
    logic [7:0] ri;
  } exp_t;

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  r;
    logic [15:0] m;
    logic [7:0]  q;
    logic [7:0]  c;
    logic [7:0]  ri;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   errors = 0;
  int   checks = 0;
  int   rises;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] outs(input int u);
    case (u)
      0:       return {a_q, a_c, a_ri};
      1:       return {4'b0, b_q, 4'b0, b_c, 4'b0, b_ri};
      2:       return {6'b0, c_q, 6'b0, c_c, 6'b0, c_ri};
      default: return {6'b0, d_q, 6'b0, d_c, 6'b0, d_ri};
    endcase
  endfunction

  task automatic expect_out(input int unit, input string name,
                            input logic [7:0] q, input logic [7:0] c,
                            input logic [7:0] ri);
    exp_t e;
    e.unit = unit;
    e.name = name;
    e.q    = q;
    e.c    = c;
    e.ri   = ri;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare every pending expectation.
  task automatic tick();
    exp_t        e;
    logic [23:0] o;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = outs(e.unit);
      chk({e.name, ".q"}, o[23:16], e.q);
      chk({e.name, ".conflict"}, o[15:8], e.c);
      chk({e.name, ".rise"}, o[7:0], e.ri);
    end
  endtask

  task automatic chk_all_zero(input string name);
    logic [23:0] o;
    for (int u = 0; u < 4; u++) begin
      o = outs(u);
      chk($sformatf("%s.u%0d", name, u), o[23:16] | o[15:8] | o[7:0], 8'h00);
    end
  endtask

  initial begin
    tbl[0]  = '{8'h05, 8'h00, 16'h00E4, 8'h05, 8'h00, 8'h05};
    tbl[1]  = '{8'h0F, 8'h0F, 16'h00E4, 8'h0E, 8'h0F, 8'h0A};
    tbl[2]  = '{8'h00, 8'h00, 16'h00E4, 8'h0E, 8'h00, 8'h00};
    tbl[3]  = '{8'h00, 8'h0C, 16'h00E4, 8'h02, 8'h00, 8'h00};
    tbl[4]  = '{8'hF0, 8'h00, 16'h00E4, 8'hF2, 8'h00, 8'hF0};
    tbl[5]  = '{8'hFF, 8'hFF, 16'h00E4, 8'h0A, 8'hFF, 8'h08};
    tbl[6]  = '{8'hFF, 8'hFF, 16'hFFFF, 8'hF5, 8'hFF, 8'hF5};
    tbl[7]  = '{8'hFF, 8'hFF, 16'hFFFF, 8'h0A, 8'hFF, 8'h0A};
    tbl[8]  = '{8'h00, 8'hFF, 16'hAAAA, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{8'h00, 8'h00, 16'hAAAA, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{8'h01, 8'h01, 16'h0001, 8'h01, 8'h01, 8'h01};
    tbl[11] = '{8'h01, 8'h01, 16'h0000, 8'h00, 8'h01, 8'h00};

    ares_L = 1'b0;
    a_mode = '0; a_s = '0; a_r = '0;
    b_mode = '0; b_s = 4'b0010; b_r = '0;
    c_mode = '0; c_s = '0; c_r = '0;
    d_mode = '0; d_s = '0; d_r = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    @(negedge clk);
    ares_L = 1'b1;

    // S already high at the first edge after reset is an edge event.
    expect_out(1, "edge_first", 8'h02, 8'h00, 8'h02);
    expect_out(0, "a_idle", 8'h00, 8'h00, 8'h00);
    tick();
    b_s = '0; b_r = 4'b0010;
    expect_out(1, "edge_clr1", 8'h00, 8'h00, 8'h00);
    tick();
    b_r = '0;

    // Async reset with all flags and pulses high.
    a_s = 8'hFF; a_r = 8'hFF; a_mode = 16'hFFFF;
    expect_out(0, "a_all_toggle", 8'hFF, 8'hFF, 8'hFF);
    tick();
    a_s = '0; a_r = '0; a_mode = '0;
    @(negedge clk);
    #2 ares_L = 1'b0;
    #1;
    chk("async_rst.q", a_q, 8'h00);
    chk("async_rst.conflict", a_c, 8'h00);
    chk("async_rst.rise", a_ri, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_held.q", a_q, 8'h00);
    @(negedge clk);
    ares_L = 1'b1;

    for (int k = 0; k < 12; k++) begin
      a_s = tbl[k].s; a_r = tbl[k].r; a_mode = tbl[k].m;
      expect_out(0, $sformatf("vec%0d", k), tbl[k].q, tbl[k].c, tbl[k].ri);
      tick();
    end
    a_s = '0; a_r = '0; a_mode = '0;

    // EDGE=1: S held 10 cycles, R pulse at cycle 3.
    rises = 0;
    for (int k = 0; k < 10; k++) begin
      b_s = 4'b0001;
      b_r = (k == 3) ? 4'b0001 : 4'b0000;
      expect_out(1, $sformatf("edge_hold%0d", k), (k < 3) ? 8'h01 : 8'h00,
                 8'h00, (k == 0) ? 8'h01 : 8'h00);
      tick();
      rises += int'(b_ri[0]);
    end
    chk("edge_rise_count", 8'(rises), 8'd1);
    b_s = '0; b_r = '0;
    expect_out(1, "edge_low", 8'h00, 8'h00, 8'h00);
    tick();
    b_s = 4'b0001;
    expect_out(1, "edge_reset_s", 8'h01, 8'h00, 8'h01);
    tick();
    b_s = '0;
    expect_out(1, "edge_hold_q", 8'h01, 8'h00, 8'h00);
    tick();
    b_s = 4'b0001; b_r = 4'b0001;
    expect_out(1, "edge_both", 8'h00, 8'h01, 8'h00);
    tick();
    expect_out(1, "edge_both_held", 8'h00, 8'h00, 8'h00);
    tick();
    b_s = '0; b_r = '0;

    // TIMEOUT=5: plain pulse, retrigger, hold conflict, toggle.
    for (int j = 0; j < 7; j++) begin
      c_s = (j == 0) ? 2'b01 : 2'b00;
      expect_out(2, $sformatf("to5_run1_%0d", j), (j < 5) ? 8'h01 : 8'h00,
                 8'h00, (j == 0) ? 8'h01 : 8'h00);
      tick();
    end
    for (int j = 0; j < 10; j++) begin
      c_s = (j == 0 || j == 3) ? 2'b01 : 2'b00;
      expect_out(2, $sformatf("to5_retrig_%0d", j), (j < 8) ? 8'h01 : 8'h00,
                 8'h00, (j == 0) ? 8'h01 : 8'h00);
      tick();
    end
    c_mode = 4'b0010;
    for (int j = 0; j < 7; j++) begin
      c_s = (j == 0 || j == 2) ? 2'b01 : 2'b00;
      c_r = (j == 2) ? 2'b01 : 2'b00;
      expect_out(2, $sformatf("to5_hold_%0d", j), (j < 5) ? 8'h01 : 8'h00,
                 (j == 2) ? 8'h01 : 8'h00, (j == 0) ? 8'h01 : 8'h00);
      tick();
    end
    c_mode = 4'b0011;
    for (int j = 0; j < 7; j++) begin
      c_s = (j == 0 || j == 2) ? 2'b01 : 2'b00;
      c_r = c_s;
      expect_out(2, $sformatf("to5_tog_%0d", j), (j < 2) ? 8'h01 : 8'h00,
                 (j == 0 || j == 2) ? 8'h01 : 8'h00,
                 (j == 0) ? 8'h01 : 8'h00);
      tick();
    end
    c_s = '0; c_r = '0; c_mode = '0;

    // TIMEOUT=3: events landing on the expiry edge.
    d_mode = 4'b0001;
    for (int j = 0; j < 18; j++) begin
      d_s = (j == 0 || j == 3 || j == 7 || j == 11 || j == 14) ? 2'b01 : 2'b00;
      d_r = (j == 10 || j == 11 || j == 14) ? 2'b01 : 2'b00;
      expect_out(3, $sformatf("to3_%0d", j),
                 (j == 6 || j == 10 || j == 17) ? 8'h00 : 8'h01,
                 (j == 11 || j == 14) ? 8'h01 : 8'h00,
                 (j == 0 || j == 7 || j == 11) ? 8'h01 : 8'h00);
      tick();
    end
    d_s = '0; d_r = '0; d_mode = '0;

    // Reset in the middle of a timeout.
    c_s = 2'b01;
    expect_out(2, "to5_mid_set", 8'h01, 8'h00, 8'h01);
    tick();
    c_s = '0;
    expect_out(2, "to5_mid_run", 8'h01, 8'h00, 8'h00);
    tick();
    @(negedge clk);
    ares_L = 1'b0;
    #1;
    chk("to5_mid_rst.q", {6'b0, c_q}, 8'h00);
    @(negedge clk);
    ares_L = 1'b1;
    for (int j = 0; j < 6; j++) begin
      expect_out(2, $sformatf("to5_after_rst_%0d", j), 8'h00, 8'h00, 8'h00);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/srff_bank.md
# srff_bank

Parametrised bank of N independent set/reset flip-flops with a per-channel conflict-resolution mode, an optional rising-edge input qualifier and an optional auto-clear timeout. It replaces single-bit set/reset flag registers wherever a group of status, enable or request flags is driven by separate set and clear strobes. Examples are interrupt-pending bits, one-shot enables and timed request lines. It sits between control logic producing strobes and any consumer needing a registered flag.

## Interface
- N, 8: channel count, 1..32.
- EDGE, 0: 0 = S/R are level-sensitive; 1 = only a rising edge of S or R is an event.
- TIMEOUT, 0: 0 = no auto-clear; T > 0 = a set Q self-clears after exactly T cycles. Range 0..65535.
- CW: localparam, counter width = max(1, clog2(TIMEOUT+1)).

Ports:
- clk  in  1  single clock, rising edge.
- ares_L  in  1  asynchronous, active-low reset.
- mode  in  2*N  per-channel conflict mode, bits [2i+1:2i] for channel i: 00 reset-wins, 01 set-wins, 10 hold, 11 toggle.
- S  in  N  set requests.
- R  in  N  reset requests.
- Q  out  N  registered flag outputs.
- conflict  out  N  registered 1-cycle pulse: eS and eR were both active at the previous edge.
- rise  out  N  registered 1-cycle pulse: Q went 0->1 at the previous edge.

## Operation
- Channels are fully independent. Everything below is per channel i.
- Effective events:
  - EDGE=0: eS = S, eR = R.
  - EDGE=1: eS = S & ~S_d, eR = R & ~R_d, where S_d and R_d are last-cycle samples.
  - S_d and R_d reset to 0, so an input already high at the first edge after reset counts as an edge.
- Next-state before timeout (nQ):
  - Neither eS nor eR: Q.
  - eS only: 1.
  - eR only: 0.
  - Both, by mode: 00 -> 0; 01 -> 1; 10 -> Q; 11 -> ~Q.
- Timeout (TIMEOUT=T>0), with per-channel counter cnt[CW-1:0]:
  - Reload: nQ=1 because of an event, i.e. eS, or toggle from 0. Then Q<=1, cnt<=T. A retrigger while Q=1 reloads.
  - Clear by event: nQ=0 because of an event. Then Q<=0, cnt<=0.
  - No event, Q=1, cnt>1: cnt<=cnt-1, Q stays 1.
  - No event, Q=1, cnt==1: Q<=0, cnt<=0 (expiry).
  - Hold-mode conflict counts as "no event"; the counter keeps decrementing.
  - Expiry in the same cycle as eS: eS wins, so Q stays 1 and cnt reloads to T.
- TIMEOUT=0: no counter is instantiated, and Q<=nQ.
- conflict <= eS & eR, independent of mode.
- rise <= ~Q & Q_next.
- mode is sampled every cycle, with no shadowing. Changing it takes effect on the same edge.

## Timing
- Reset (ares_L low, async): Q=0, conflict=0, rise=0, cnt=0, S_d=0, R_d=0. Outputs clear immediately, without waiting for clk.
- Reset release is synchronous to the next clk edge.
- Reset mid-timeout: Q clears at once and the counter is abandoned.
- Latency: S/R sampled at edge k drive Q after edge k, i.e. 1 cycle from input to Q. This is the same for EDGE=1; the edge qualifier adds no cycles.
- conflict and rise are asserted in the cycle after edge k, for exactly one cycle.
- Timeout: Q set at edge k stays high for exactly T cycles and falls at edge k+T, unless retriggered or reset.
  - T=1 gives a 1-cycle pulse.
- EDGE=1: S held high for many cycles is a single event. A new event needs S low for at least one sampled cycle.
- No combinational path from any input to any output.

## Test plan
- Reset: assert ares_L low mid-cycle with Q=8'hFF. Required: Q, conflict and rise are 0 before the next clk edge.
- Modes (N=4, mode=8'b11_10_01_00, Q=4'b0101, S=R=4'hF for one cycle). Required:
  - Q=4'b1110 next cycle.
  - conflict=4'hF for one cycle.
  - rise=4'b1010.
- EDGE=1: hold S[0] high for 10 cycles, with Q[0] cleared by an R pulse at cycle 3. Required: Q[0] is 0 from cycle 4 onward, and there is only one rise pulse.
- TIMEOUT=5, set pulse at edge 10. Required: Q high across edges 10..14 and low at edge 15. Then retrigger at edge 13 of a second run; required: Q falls at edge 18.
- TIMEOUT=3: S pulse at the expiry edge. Required: Q stays 1 and falls 3 cycles later. Then R with mode=01 at the expiry edge; required: Q=0.
